// File: rtl/mdu_alu_pkg.sv
// rtl/mdu_alu_pkg.sv - shared opcode and sequencer state constants for mdu_alu
package mdu_alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_MULT  = 4'd6;
  localparam logic [3:0] OP_MULTU = 4'd7;
  localparam logic [3:0] OP_DIV   = 4'd8;
  localparam logic [3:0] OP_DIVU  = 4'd9;
  localparam logic [3:0] OP_MTHI  = 4'd10;
  localparam logic [3:0] OP_MTLO  = 4'd11;
  localparam logic [3:0] OP_SLL   = 4'd12;
  localparam logic [3:0] OP_SRA   = 4'd13;
  localparam logic [3:0] OP_MFLO  = 4'd14;
  localparam logic [3:0] OP_MFHI  = 4'd15;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Sizes the shared busy counter so it holds the longer of the two latencies.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - multiply/divide sequencer: IDLE/BUSY FSM, cycle counter, HI/LO registers
module mdu_seq
  import mdu_alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] a2_i,
  input  logic [3:0]       op_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(max_int(MUL_CYCLES, DIV_CYCLES) + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   divisor, quo_s, rem_s, quo_u, rem_u;

  // Result datapath on the latched operands; a zero or overflowing divisor is
  // replaced by 1 so the divider never traps, and for most-negative / -1 that
  // substitution directly gives the wanted LO = most-negative, HI = 0.
  always_comb begin
    prod_s   = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    div_zero = (b_q == '0);
    div_ovf  = (op_q == OP_DIV) && (a_q == MOST_NEG) && (b_q == '1);
    divisor  = (div_zero || div_ovf) ? WIDTH'(1) : b_q;
    quo_s    = $signed(a_q) / $signed(divisor);
    rem_s    = $signed(a_q) % $signed(divisor);
    quo_u    = a_q / divisor;
    rem_u    = a_q % divisor;
  end

  // Next-state logic: launch long ops or move-to in IDLE, count down in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          case (op_i)
            OP_MULT, OP_MULTU: begin
              state_d = ST_BUSY;
              cnt_d   = CNT_W'(MUL_CYCLES);
              op_d    = op_i;
              a_d     = a1_i;
              b_d     = a2_i;
            end
            OP_DIV, OP_DIVU: begin
              state_d = ST_BUSY;
              cnt_d   = CNT_W'(DIV_CYCLES);
              op_d    = op_i;
              a_d     = a1_i;
              b_d     = a2_i;
            end
            OP_MTHI: hi_d = a1_i;
            OP_MTLO: lo_d = a1_i;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              if (!div_zero) begin
                lo_d = quo_s;
                hi_d = rem_s;
              end
            end
            OP_DIVU: begin
              if (!div_zero) begin
                lo_d = quo_u;
                hi_d = rem_u;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight operation.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o = (state_q == ST_BUSY);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/mdu_alu.sv
// rtl/mdu_alu.sv - ALU with multi-cycle mult/div; MDU_ALU_SHIFT_EN adds sll/sra on ops 12/13
module mdu_alu
  import mdu_alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [3:0]       ALU_op,
  input  logic             start,
  output logic [WIDTH-1:0] ans,
  output logic             ALU_Ov_op,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

`ifdef MDU_ALU_SHIFT_EN
  localparam int SH_W = $clog2(WIDTH);
`endif

  logic [WIDTH:0] sum_ext, diff_ext;

  assign sum_ext  = {A1[WIDTH-1], A1} + {A2[WIDTH-1], A2};
  assign diff_ext = {A1[WIDTH-1], A1} - {A2[WIDTH-1], A2};

  mdu_seq #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_seq (
    .clk_i   (clk),
    .reset_i (reset),
    .a1_i    (A1),
    .a2_i    (A2),
    .op_i    (ALU_op),
    .start_i (start),
    .busy_o  (busy),
    .hi_o    (HI),
    .lo_o    (LO)
  );

  // Zero-latency result path; overflowing add/sub returns 0 with the flag set.
  always_comb begin
    ans       = '0;
    ALU_Ov_op = 1'b0;
    case (ALU_op)
      OP_ADD: begin
        if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) ALU_Ov_op = 1'b1;
        else                                    ans       = sum_ext[WIDTH-1:0];
      end
      OP_SUB: begin
        if (diff_ext[WIDTH] != diff_ext[WIDTH-1]) ALU_Ov_op = 1'b1;
        else                                      ans       = diff_ext[WIDTH-1:0];
      end
      OP_OR:   ans = A1 | A2;
      OP_AND:  ans = A1 & A2;
      OP_SLTU: ans = {{(WIDTH-1){1'b0}}, (A1 < A2)};
      OP_SLT:  ans = {{(WIDTH-1){1'b0}}, ($signed(A1) < $signed(A2))};
      OP_MFHI: ans = HI;
      OP_MFLO: ans = LO;
`ifdef MDU_ALU_SHIFT_EN
      OP_SLL:  ans = A2 << A1[SH_W-1:0];
      OP_SRA:  ans = $signed(A2) >>> A1[SH_W-1:0];
`else
      OP_SLL, OP_SRA: ans = '0;
`endif
      default: ans = '0;
    endcase
  end

endmodule

// File: doc/mdu_alu.md
MDU_ALU -- requirements
Module: mdu_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand, result and HI/LO width in bits.
REQ-002 The block SHALL have parameter MUL_CYCLES, default 5, giving the busy duration in cycles of mult/multu.
REQ-003 The block SHALL have parameter DIV_CYCLES, default 10, giving the busy duration in cycles of div/divu.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have ports A1 and A2, input, WIDTH bits each: operands.
REQ-008 The block SHALL have port ALU_op, input, 4 bits: operation select (encoding in REQ-012).
REQ-009 The block SHALL have port start, input, 1 bit: qualifies the multi-cycle ops 6-11.
REQ-010 The block SHALL have these outputs:
- ans, WIDTH bits: combinational result.
- ALU_Ov_op, 1 bit: signed overflow.
- busy, 1 bit: multi-cycle operation in flight.
- HI and LO, WIDTH bits each: registered multiply/divide results.

Function
REQ-011 Ops 0-5 SHALL be combinational with zero latency, independent of start and busy.
REQ-012 The opcode encoding SHALL be:
- 0 add, 1 sub, 2 or, 3 and, 4 sltu, 5 slt.
- 6 mult, 7 multu, 8 div, 9 divu, 10 mthi, 11 mtlo.
- 15 mfhi, 14 mflo.
- 12-13 reserved, unless REQ-024 applies.
REQ-013 Add/sub overflow SHALL be detected using a WIDTH+1-bit sign-extended sum whose top two bits differ; on overflow ALU_Ov_op=1 and ans=0, otherwise ALU_Ov_op=0 and ans=the WIDTH-bit sum/difference.
REQ-014 For all non-add/sub ops, ALU_Ov_op SHALL be 0.
REQ-015 Reserved ops SHALL drive ans=0.
REQ-016 ans SHALL return HI for mfhi and LO for mflo.
REQ-017 The sequencer SHALL be a two-state FSM, IDLE and BUSY, with a cycle counter; busy=1 exactly when the FSM is in BUSY.
REQ-018 In IDLE, start=1 with mult/multu/div/divu SHALL:
- latch the operands and op;
- enter BUSY with counter = MUL_CYCLES or DIV_CYCLES respectively;
- raise busy from the next cycle, holding it for exactly that many cycles.
REQ-019 On the edge ending the last BUSY cycle, the block SHALL write HI/LO and return to IDLE:
- mult/multu: {HI,LO} = 2*WIDTH-bit signed/unsigned product.
- div/divu: LO = quotient, HI = remainder, signed results truncate toward zero and the remainder takes the dividend's sign.
REQ-020 Divide by zero SHALL complete after DIV_CYCLES with HI and LO unchanged; overflow division (most-negative / -1) SHALL yield LO = most-negative value, HI = 0.
REQ-021 start with mthi/mtlo in IDLE SHALL write A1 to HI/LO at that edge with no busy cycle; start of any op while busy=1 SHALL be ignored, and the in-flight op and HI/LO SHALL be unaffected.
REQ-022 mfhi/mflo issued during BUSY SHALL return the pre-operation HI/LO; the upstream stage stalls on busy.

Reset
REQ-023 reset=1 at a clock edge SHALL force IDLE, counter=0, busy=0, HI=0, LO=0, including mid-operation, where the in-flight result is discarded; the combinational outputs ans and ALU_Ov_op SHALL be unaffected by reset.

Configuration
REQ-024 With macro MDU_ALU_SHIFT_EN defined, op 12 SHALL be sll (A2 << A1[log2 WIDTH-1:0]) and op 13 SHALL be sra (arithmetic right shift); without it, ops 12-13 SHALL be reserved (ans=0), with no shifter logic generated.

Structure
REQ-025 The op encodings and the state encodings (IDLE/BUSY) SHALL be constants in a shared package, mdu_alu_pkg.
REQ-026 The block SHALL contain one sub-module, mdu_seq, holding the FSM, counter and HI/LO registers; the combinational datapath stays in mdu_alu.

Verification
REQ-027 The bench SHALL cover, with WIDTH=32:
- add 0x7FFFFFFF+1 -> ALU_Ov_op=1, ans=0.
- sub 5-7 -> ans=0xFFFFFFFE, ALU_Ov_op=0.
- mult 0xFFFFFFFF*2 with start -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu on the same operands -> HI=1, LO=0xFFFFFFFE.
- div -7/2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 9/0 -> HI/LO unchanged after 10 cycles.
- start mult while busy -> ignored; mfhi during busy -> returns the old HI.
- reset asserted in the 3rd busy cycle -> busy=0, HI=LO=0 on the next cycle.
- mthi 0x1234 -> HI=0x1234 on the next cycle, busy stays 0.
- with MDU_ALU_SHIFT_EN: sra of 0x80000000 by 4 -> ans=0xF8000000.
